// File: rtl/dsa_sample_sched.sv
// rtl/dsa_sample_sched.sv - sample scheduler and soft-mute gain ramp ahead of the delta-sigma modulator
module dsa_sample_sched #(
   parameter int DAC_BW     = 16,
   parameter int OSR        = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int PRIME_LVL  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              mute,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DAC_BW-1:0] s_data,
   output logic [DAC_BW-1:0] dac_din,
   output logic              dac_rst_n,
   output logic              underrun,
   output logic              busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OSR_W = $clog2(OSR);
   localparam int PW    = DAC_BW + 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [OSR_W-1:0]  cnt;
   logic [4:0]        g;
   logic [4:0]        g_new;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DAC_BW-1:0] mem [FIFO_DEPTH];

   logic              running;
   logic              strobe;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              flush;
   logic [DAC_BW-1:0] sample_sel;
   logic signed [PW-1:0] smp_ext;
   logic signed [PW-1:0] gain_ext;
   logic signed [PW-1:0] prod;
   logic [DAC_BW-1:0] scaled;
   logic              unused_prod_bits;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign running    = (state == S_RUN) || (state == S_DRAIN);
   assign strobe     = running && (cnt == '0);
   assign fifo_empty = (count == '0);
   // reset gating keeps s_ready low while rst is held, even with enable high
   assign s_ready    = !rst && enable && (state != S_DRAIN) && (count < CNT_W'(FIFO_DEPTH));
   assign push       = s_valid && s_ready;
   assign pop        = strobe && !fifo_empty;
   assign flush      = (state != S_IDLE) && (state_nx == S_IDLE);
   assign busy       = (state != S_IDLE);

   // an empty FIFO at the strobe plays silence rather than a stale entry
   assign sample_sel = fifo_empty ? '0 : mem[rd_ptr];

   // gain scaling: signed sample times zero-extended gain, then divide by 16 with floor
   assign smp_ext  = PW'($signed(sample_sel));
   assign gain_ext = PW'({1'b0, g_new});
   assign prod     = smp_ext * gain_ext;
   assign scaled   = prod[DAC_BW+3:4];
   assign unused_prod_bits = ^{prod[PW-1:DAC_BW+4], prod[3:0]};

   // gain step taken at the next strobe: ramp up while playing, down when muted or draining
   always_comb begin
      g_new = g;
      if ((state == S_RUN) && !mute) begin
         g_new = (g == 5'd16) ? g : g + 5'd1;
      end else if (g != 5'd0) begin
         g_new = g - 5'd1;
      end
   end

   // playback state transitions
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (enable) state_nx = S_PRIME;
         S_PRIME: begin
            if (!enable)                           state_nx = S_IDLE;
            else if (count >= CNT_W'(PRIME_LVL))   state_nx = S_RUN;
         end
         S_RUN:   if (!enable) state_nx = S_DRAIN;
         S_DRAIN: if (strobe && (g_new == 5'd0)) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // sample storage; occupancy tracking lives with the FSM so a flush wins over push/pop
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   // FSM, rate counter, gain, FIFO pointers and registered modulator outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         g         <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         dac_din   <= '0;
         dac_rst_n <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state <= state_nx;

         if (running) begin
            cnt <= (cnt == OSR_W'(OSR - 1)) ? '0 : cnt + 1'b1;
         end else begin
            cnt <= '0;
         end

         if ((state == S_IDLE) && (state_nx == S_PRIME)) begin
            g <= '0;
         end else if (strobe) begin
            g <= g_new;
         end

         if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end

         underrun <= strobe && fifo_empty;

         if (state_nx == S_IDLE) begin
            dac_din <= '0;
         end else if (strobe) begin
            dac_din <= scaled;
         end

         dac_rst_n <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      end
   end

endmodule

// File: tb/tb_dsa_sample_sched.sv
// tb/tb_dsa_sample_sched.sv - self-checking bench for dsa_sample_sched
module tb_dsa_sample_sched;

   localparam int DAC_BW     = 16;
   localparam int OSR        = 64;
   localparam int FIFO_DEPTH = 4;
   localparam int PRIME_LVL  = 2;

   localparam int M_IDLE  = 0;
   localparam int M_PRIME = 1;
   localparam int M_RUN   = 2;
   localparam int M_DRAIN = 3;

   logic              clk;
   logic              rst;
   logic              enable;
   logic              mute;
   logic              s_valid;
   logic              s_ready;
   logic [DAC_BW-1:0] s_data;
   logic [DAC_BW-1:0] dac_din;
   logic              dac_rst_n;
   logic              underrun;
   logic              busy;

   int n_cmp;
   int n_bad;

   dsa_sample_sched #(
      .DAC_BW(DAC_BW), .OSR(OSR), .FIFO_DEPTH(FIFO_DEPTH), .PRIME_LVL(PRIME_LVL)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mute(mute),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .dac_din(dac_din), .dac_rst_n(dac_rst_n), .underrun(underrun), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DAC_BW-1:0] q[$];
   int                mph;
   int                mg;
   int                mtick;
   logic [DAC_BW-1:0] e_din;
   logic              e_rstn;
   logic              e_under;
   int                m_sz0;
   bit                m_stb;
   bit                m_acc;
   logic [DAC_BW-1:0] m_smp;

   function automatic logic m_ready();
      return !rst && enable && (mph != M_DRAIN) && (q.size() < FIFO_DEPTH);
   endfunction

   // floor(sample * g / 16) computed with plain integer arithmetic
   function automatic logic [DAC_BW-1:0] scale(input logic [DAC_BW-1:0] s, input int g);
      int p;
      p = $signed(s) * g;
      if (p >= 0) return DAC_BW'(p / 16);
      return DAC_BW'(-((-p + 15) / 16));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         mph = M_IDLE; mg = 0; mtick = 0;
         e_din = '0; e_rstn = 1'b0; e_under = 1'b0;
      end else begin
         m_sz0 = q.size();
         m_acc = s_valid && m_ready();
         m_stb = ((mph == M_RUN) || (mph == M_DRAIN)) && (mtick % OSR == 0);
         e_under = 1'b0;
         if (m_stb) begin
            if (m_sz0 > 0) m_smp = q.pop_front();
            else begin m_smp = '0; e_under = 1'b1; end
            if ((mph == M_RUN) && !mute) mg = (mg < 16) ? mg + 1 : 16;
            else                         mg = (mg > 0) ? mg - 1 : 0;
            e_din = scale(m_smp, mg);
         end
         if (m_acc) q.push_back(s_data);
         case (mph)
            M_IDLE:  if (enable) begin mph = M_PRIME; mg = 0; end
            M_PRIME: begin
               if (!enable) begin mph = M_IDLE; q.delete(); end
               else if (m_sz0 >= PRIME_LVL) begin mph = M_RUN; mtick = 0; end
            end
            M_RUN:   begin mtick++; if (!enable) mph = M_DRAIN; end
            default: begin
               mtick++;
               if (m_stb && (mg == 0)) begin mph = M_IDLE; q.delete(); end
            end
         endcase
         if (mph == M_IDLE) e_din = '0;
         e_rstn = (mph == M_RUN) || (mph == M_DRAIN);
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      chk("m_dac_din",   dac_din,   e_din);
      chk("m_dac_rst_n", dac_rst_n, e_rstn);
      chk("m_underrun",  underrun,  e_under);
      chk("m_busy",      busy,      mph != M_IDLE);
      chk("m_s_ready",   s_ready,   m_ready());
   end

   // ---------------- upstream source ----------------
   logic              src_on;
   logic [DAC_BW-1:0] src_val;
   logic [DAC_BW-1:0] src_inc;
   logic              acc_pending;

   initial begin
      s_valid = 1'b0; s_data = '0; acc_pending = 1'b0;
      forever begin
         @(negedge clk); #2;
         acc_pending = s_valid && s_ready;
         @(posedge clk); #1;
         if (acc_pending) src_val = src_val + src_inc;
         s_valid = src_on;
         s_data  = src_val;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_run();
      int k;
      k = 0;
      while ((dac_rst_n !== 1'b1) && (k < 200)) begin
         cyc(1);
         k++;
      end
      chk("run_entry", dac_rst_n, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   logic [DAC_BW-1:0] prev;

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1; enable = 1'b1; mute = 1'b0;
      src_on = 1'b0; src_val = '0; src_inc = '0;
      cyc(3);
      chk("rst_s_ready",   s_ready,   1'b0);
      chk("rst_dac_din",   dac_din,   16'h0000);
      chk("rst_dac_rst_n", dac_rst_n, 1'b0);
      chk("rst_underrun",  underrun,  1'b0);
      chk("rst_busy",      busy,      1'b0);

      // startup ramp with full-scale positive input
      rst = 1'b0;
      src_val = 16'h7FFF; src_on = 1'b1;
      wait_run();
      cyc(1);
      chk("ramp_s1", dac_din, 16'h07FF);
      cyc(64);
      chk("ramp_s2", dac_din, 16'h0FFF);
      cyc(63);
      chk("ramp_s2_hold", dac_din, 16'h0FFF);
      cyc(1 + 13 * 64);
      chk("ramp_s16", dac_din, 16'h7FFF);

      // back-pressure with a sequence counter
      src_val = 16'h0001; src_inc = 16'h0001;
      prev = '0;
      for (int i = 0; i < 12; i++) begin
         cyc(64);
         if (i >= 6) chk("seq_step", dac_din, prev + 16'h0001);
         prev = dac_din;
      end
      chk("bp_ready_after_strobe", s_ready, 1'b1);
      cyc(1);
      chk("bp_ready_full", s_ready, 1'b0);
      cyc(63);

      // underrun once the FIFO runs dry
      src_on = 1'b0; src_inc = '0;
      cyc(6 * 64);
      chk("ur_pulse", underrun, 1'b1);
      chk("ur_din",   dac_din,  16'h0000);
      cyc(1);
      chk("ur_clear", underrun, 1'b0);
      src_val = 16'h0100; src_on = 1'b1;
      cyc(63);
      chk("ur_resume", dac_din, 16'h0100);

      // mute ramp with negative full scale
      src_val = 16'h8000;
      cyc(6 * 64);
      chk("mute_pre", dac_din, 16'h8000);
      mute = 1'b1;
      cyc(64);
      chk("mute_s1", dac_din, 16'h8800);
      chk("mute_rstn", dac_rst_n, 1'b1);
      cyc(64);
      chk("mute_s2", dac_din, 16'h9000);
      cyc(14 * 64);
      chk("mute_zero", dac_din, 16'h0000);
      chk("mute_zero_rstn", dac_rst_n, 1'b1);
      mute = 1'b0;
      cyc(64);
      chk("unmute_s1", dac_din, 16'hF800);
      cyc(15 * 64);
      chk("unmute_s16", dac_din, 16'h8000);

      // stop and drain, re-enable mid-drain is ignored
      enable = 1'b0;
      #1;
      chk("stop_ready", s_ready, 1'b0);
      chk("stop_busy",  busy,    1'b1);
      cyc(64);
      chk("drain_s1", dac_din, 16'h8800);
      cyc(2 * 64);
      chk("drain_s3", dac_din, 16'h9800);
      enable = 1'b1;
      #1;
      chk("drain_reen_ready", s_ready, 1'b0);
      cyc(13 * 64);
      chk("idle_busy", busy,      1'b0);
      chk("idle_rstn", dac_rst_n, 1'b0);
      chk("idle_din",  dac_din,   16'h0000);
      cyc(1);
      chk("reprime_busy", busy,      1'b1);
      chk("reprime_rstn", dac_rst_n, 1'b0);

      // async reset in the middle of a drain
      wait_run();
      cyc(1);
      chk("rerun_s1", dac_din, 16'hF800);
      cyc(2 * 64);
      chk("rerun_s3", dac_din, 16'hE800);
      enable = 1'b0;
      cyc(64);
      chk("drain2_s1", dac_din, 16'hF000);
      #2;
      rst = 1'b1; enable = 1'b1;
      #1;
      chk("arst_s_ready",   s_ready,   1'b0);
      chk("arst_dac_din",   dac_din,   16'h0000);
      chk("arst_dac_rst_n", dac_rst_n, 1'b0);
      chk("arst_underrun",  underrun,  1'b0);
      chk("arst_busy",      busy,      1'b0);
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("post_rst_busy", busy,      1'b1);
      chk("post_rst_rstn", dac_rst_n, 1'b0);
      wait_run();
      cyc(4 * 64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
